desc_sort_stream: RTL and testbench



---
 rtl/desc_sort_stream.sv | 153 +++++++++++++++
 tb/tb_desc_sort_stream.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/desc_sort_stream.sv
// desc_sort_stream: captures one vector of N words and streams them out greatest
// first, one word per accepted beat, each tagged with its original slot index.
// Build option: define SORTER_SIGNED_EN to compare words as two's-complement
// signed values. The default build compares unsigned. Ties always go to the
// lowest slot index, and the interface is the same in both builds.
module desc_sort_stream #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int IDXW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [IDXW-1:0]      out_idx,
    output logic                 out_last
);

    // The search tree is padded to a power of two. Padding leaves never win.
    localparam int LEAVES = 1 << IDXW;
    localparam int NODES  = 2 * LEAVES - 1;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [N-1:0]     used_q;
    logic [IDXW-1:0]  cnt_q;
    logic [WIDTH-1:0] word_q [N];

    logic [WIDTH-1:0] in_word_d [N];
    logic             capture_d;
    logic             advance_d;
    logic             last_d;
    logic [WIDTH-1:0] max_data_d;
    logic [IDXW-1:0]  max_idx_d;

    // Node arrays for the selection tree. Node n has children 2n+1 and 2n+2.
    // The leaves start at LEAVES-1.
    logic [WIDTH-1:0] t_data [NODES];
    logic [IDXW-1:0]  t_idx  [NODES];
    logic             t_vld  [NODES];

    // Returns 1 when a is greater than or equal to b in the selected number format.
    function automatic logic word_ge(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SORTER_SIGNED_EN
        return $signed(a) >= $signed(b);
`else
        return a >= b;
`endif
    endfunction

    // Split the packed input bus into per-slot words.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            assign in_word_d[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // in_ready is high only in IDLE, and out_valid is high only in EMIT.
    assign capture_d = in_ready_q && in_valid;
    assign advance_d = out_valid_q && out_ready;
    assign last_d    = out_valid_q && (cnt_q == IDXW'(N - 1));

    // Balanced max tree over the unused entries. On a tie the left child wins,
    // and the left child always holds the lower indices.
    always_comb begin
        for (int k = 0; k < NODES; k++) begin
            t_data[k] = '0;
            t_idx[k]  = '0;
            t_vld[k]  = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            t_data[LEAVES-1+k] = word_q[k];
            t_idx[LEAVES-1+k]  = IDXW'(k);
            t_vld[LEAVES-1+k]  = ~used_q[k];
        end
        for (int n = LEAVES - 2; n >= 0; n--) begin
            if (t_vld[2*n+1] && (!t_vld[2*n+2] || word_ge(t_data[2*n+1], t_data[2*n+2]))) begin
                t_data[n] = t_data[2*n+1];
                t_idx[n]  = t_idx[2*n+1];
            end else begin
                t_data[n] = t_data[2*n+2];
                t_idx[n]  = t_idx[2*n+2];
            end
            t_vld[n] = t_vld[2*n+1] || t_vld[2*n+2];
        end
        max_data_d = t_data[0];
        max_idx_d  = t_idx[0];
    end

    // Word store. It is loaded only at the capture edge, and reset leaves its contents as they are.
    always_ff @(posedge clk) begin
        if (capture_d) begin
            word_q <= in_word_d;
        end
    end

    // Control FSM with registered handshake flags, the emitted-slot mask and the beat count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            used_q      <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (capture_d) begin
                        state_q     <= ST_EMIT;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        used_q      <= '0;
                        cnt_q       <= '0;
                    end
                end
                ST_EMIT: begin
                    if (advance_d) begin
                        used_q[max_idx_d] <= 1'b1;
                        cnt_q             <= cnt_q + IDXW'(1);
                        if (last_d) begin
                            state_q     <= ST_IDLE;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // The data and index outputs are forced to zero when no beat is being offered.
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? max_data_d : '0;
    assign out_idx   = out_valid_q ? max_idx_d : '0;
    assign out_last  = last_d;

endmodule

// File: tb/tb_desc_sort_stream.sv
// Testbench for desc_sort_stream. It drives directed N=4/WIDTH=16 vectors and
// random N=8/WIDTH=8 vectors. A queue holds the expected beats, and monitors
// compare them against the DUT outputs.
module tb_desc_sort_stream;

    localparam int AW = 16;
    localparam int AN = 4;
    localparam int AI = 2;
    localparam int BW = 8;
    localparam int BN = 8;
    localparam int BI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic              a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [AN*AW-1:0]  a_in_data;
    logic [AW-1:0]     a_out_data;
    logic [AI-1:0]     a_out_idx;

    logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [BN*BW-1:0]  b_in_data;
    logic [BW-1:0]     b_out_data;
    logic [BI-1:0]     b_out_idx;
    logic              b_run;

    typedef struct {
        logic [63:0] data;
        int          idx;
        bit          last;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];

    int errors = 0;
    int checks = 0;

    desc_sort_stream #(.WIDTH(AW), .N(AN)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_idx(a_out_idx), .out_last(a_out_last)
    );

    desc_sort_stream #(.WIDTH(BW), .N(BN)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_idx(b_out_idx), .out_last(b_out_last)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [63:0] d, input int i, input bit l);
        qa.push_back('{data: d, idx: i, last: l});
    endtask

    // Reference ordering for the random vectors.
    function automatic bit b_gt(input logic [BW-1:0] x, input logic [BW-1:0] y);
`ifdef SORTER_SIGNED_EN
        return $signed(x) > $signed(y);
`else
        return x > y;
`endif
    endfunction

    // Monitor for DUT A: pops and compares each accepted beat.
    always @(negedge clk) begin
        if (rst === 1'b0 && a_out_valid === 1'b1) begin
            check("a_in_ready_low_in_emit", a_in_ready, 1'b0);
            if (a_out_ready === 1'b1) begin
                $display("a beat data=%h idx=%0d last=%0b", a_out_data, a_out_idx, a_out_last);
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_extra_beat: got data %h idx %0d, expected no beat", a_out_data, a_out_idx);
                end else begin
                    beat_t e;
                    e = qa.pop_front();
                    check("a_data", a_out_data, e.data);
                    check("a_idx", a_out_idx, e.idx);
                    check("a_last", a_out_last, e.last);
                end
            end
        end
    end

    // Monitor for DUT B.
    always @(negedge clk) begin
        if (rst === 1'b0 && b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_extra_beat: got data %h idx %0d, expected no beat", b_out_data, b_out_idx);
            end else begin
                beat_t e;
                e = qb.pop_front();
                check("b_data", b_out_data, e.data);
                check("b_idx", b_out_idx, e.idx);
                check("b_last", b_out_last, e.last);
            end
        end
    end

    // Hold checker for DUT A: a beat that was not accepted must stay unchanged.
    logic          p_v, p_r, p_rst, p_l;
    logic [AW-1:0] p_d;
    logic [AI-1:0] p_i;
    initial begin
        p_v = 1'b0; p_r = 1'b0; p_rst = 1'b1; p_l = 1'b0; p_d = '0; p_i = '0;
    end
    always @(negedge clk) begin
        if (p_rst === 1'b0 && rst === 1'b0 && p_v === 1'b1 && p_r === 1'b0) begin
            check("a_hold_valid", a_out_valid, 1'b1);
            check("a_hold_data", a_out_data, p_d);
            check("a_hold_idx", a_out_idx, p_i);
            check("a_hold_last", a_out_last, p_l);
        end
        p_v = a_out_valid; p_r = a_out_ready; p_rst = rst;
        p_d = a_out_data;  p_i = a_out_idx;   p_l = a_out_last;
    end

    // Random back-pressure for DUT B.
    always @(posedge clk) begin
        #1;
        b_out_ready = b_run ? ($urandom_range(0, 3) != 0) : 1'b0;
    end

    task automatic send_a(input logic [AN*AW-1:0] d);
        int t;
        t = 0;
        a_in_data  = d;
        a_in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (a_in_ready === 1'b1) break;
            t++;
            if (t > 200) begin
                $display("FAIL a_send_timeout: got in_ready %b expected 1", a_in_ready);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [BN*BW-1:0] d);
        int t;
        t = 0;
        b_in_data  = d;
        b_in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (b_in_ready === 1'b1) break;
            t++;
            if (t > 200) begin
                $display("FAIL b_send_timeout: got in_ready %b expected 1", b_in_ready);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain_a(input string name);
        for (int c = 0; c < 200; c++) begin
            if (qa.size() == 0 && a_in_ready === 1'b1) break;
            @(posedge clk);
            #1;
        end
        check(name, qa.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] w [BN];
        int            ord [BN];
        int            rank;
        int            c;

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", a_in_ready, 1'b1);
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_out_last", a_out_last, 1'b0);
        check("rst_out_data", a_out_data, 0);
        check("rst_out_idx", a_out_idx, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic vector with timing. Slots a..d are 0x0010, 0x00FF, 0x0100, 0x0003.
        a_out_ready = 1'b1;
        push_a(16'h0100, 2, 0); push_a(16'h00FF, 1, 0);
        push_a(16'h0010, 0, 0); push_a(16'h0003, 3, 1);
        send_a({16'h0003, 16'h0100, 16'h00FF, 16'h0010});
        check("t1_valid_T1", a_out_valid, 1'b1);
        check("t1_data_T1", a_out_data, 16'h0100);
        check("t1_in_ready_T1", a_in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t1_in_ready_T4", a_in_ready, 1'b0);
        check("t1_last_T4", a_out_last, 1'b1);
        @(posedge clk);
        #1;
        check("t1_in_ready_T5", a_in_ready, 1'b1);
        check("t1_valid_T5", a_out_valid, 1'b0);
        check("t1_data_gated_T5", a_out_data, 0);
        drain_a("t1_drain");

        // All words equal: the slots come out in ascending index order.
        for (int i = 0; i < 4; i++) push_a(16'h0055, i, i == 3);
        send_a({16'h0055, 16'h0055, 16'h0055, 16'h0055});
        drain_a("t2_drain");

        // Back-pressure while a second vector is held on the input.
        push_a(16'h4444, 1, 0); push_a(16'h3333, 3, 0);
        push_a(16'h2222, 2, 0); push_a(16'h1111, 0, 1);
        push_a(16'h0009, 1, 0); push_a(16'h0009, 2, 0);
        push_a(16'h0001, 3, 0); push_a(16'h0000, 0, 1);
        send_a({16'h3333, 16'h2222, 16'h4444, 16'h1111});
        a_in_valid = 1'b1;
        a_in_data  = {16'h0001, 16'h0009, 16'h0009, 16'h0000};
        c = 0;
        while (c < 100) begin
            a_out_ready = (c % 4 == 0) || (c % 4 == 3);
            @(negedge clk);
            if (a_in_ready === 1'b1) break;
            @(posedge clk);
            #1;
            c++;
        end
        check("t3_bp_bounded", c < 100, 1'b1);
        @(posedge clk);
        #1;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        drain_a("t3_drain");

        // Reset after two beats of a vector.
        push_a(16'h0100, 2, 0); push_a(16'h00FF, 1, 0);
        push_a(16'h0010, 0, 0); push_a(16'h0003, 3, 1);
        send_a({16'h0003, 16'h0100, 16'h00FF, 16'h0010});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t4_rst_valid", a_out_valid, 1'b0);
        check("t4_rst_in_ready", a_in_ready, 1'b1);
        check("t4_rst_last", a_out_last, 1'b0);
        check("t4_rst_data", a_out_data, 0);
        check("t4_beats_left", qa.size(), 2);
        qa.delete();
        rst = 1'b0;
        a_out_ready = 1'b1;
        push_a(16'h0004, 3, 0); push_a(16'h0003, 2, 0);
        push_a(16'h0002, 1, 0); push_a(16'h0001, 0, 1);
        send_a({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        drain_a("t4_drain");

        // Mixed-sign words. Slots a..d are 0xFFFF, 0x0001, 0x8000, 0x7FFF.
`ifdef SORTER_SIGNED_EN
        push_a(16'h7FFF, 3, 0); push_a(16'h0001, 1, 0);
        push_a(16'hFFFF, 0, 0); push_a(16'h8000, 2, 1);
`else
        push_a(16'hFFFF, 0, 0); push_a(16'h8000, 2, 0);
        push_a(16'h7FFF, 3, 0); push_a(16'h0001, 1, 1);
`endif
        send_a({16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF});
        drain_a("t5_drain");

        // Random N=8 vectors with random back-pressure.
        b_run = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            for (int k = 0; k < BN; k++) begin
                if (v % 4 == 0) w[k] = BW'($urandom_range(0, 3));
                else            w[k] = BW'($urandom);
            end
            for (int k = 0; k < BN; k++) begin
                rank = 0;
                for (int j = 0; j < BN; j++) begin
                    if (b_gt(w[j], w[k]) || (w[j] == w[k] && j < k)) rank++;
                end
                ord[rank] = k;
            end
            for (int r = 0; r < BN; r++) begin
                qb.push_back('{data: 64'(w[ord[r]]), idx: ord[r], last: (r == BN - 1)});
            end
            send_b({w[7], w[6], w[5], w[4], w[3], w[2], w[1], w[0]});
            $display("b vector %0d accepted: %h", v, b_in_data);
        end
        for (int t = 0; t < 2000; t++) begin
            if (qb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("b_drain", qb.size(), 0);
        b_run = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
